// File: rtl/audio_codec_config_if.sv
// Handshake between the codec config sequencer and the I2C byte-writer.
// The sequencer drives start/data; the writer returns done/ack.
interface audio_codec_config_if;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (output i2c_start, output i2c_data, input i2c_done, input i2c_ack);
  modport slave  (input i2c_start, input i2c_data, output i2c_done, output i2c_ack);
endinterface

// File: rtl/audio_codec_config.sv
// SSM2603 power-up sequencer: walks an 11-entry register table through the
// I2C byte-writer, retrying NACKed or timed-out writes.
module audio_codec_config #(
  parameter int unsigned INIT_DELAY  = 50000,
  parameter int unsigned TIMEOUT     = 8191,
  parameter int unsigned MAX_RETRIES = 3,
  parameter logic [7:0]  DEV_ADDR    = 8'h34
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        restart,
  audio_codec_config_if.master        i2c,
  output logic                        config_done,
  output logic                        config_error,
  output logic [3:0]                  err_index
);

  localparam int unsigned CNT_MAX  = (INIT_DELAY > TIMEOUT) ? INIT_DELAY : TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned RTY_W    = 3;
  localparam int unsigned WORD_W   = 24;
  localparam int unsigned LAST_IDX = 10;

  typedef enum logic [2:0] {
    S_DELAY, S_LOAD, S_RUN, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [RTY_W-1:0]    rty_q, rty_n;
  logic                pass_q, pass_n;
  logic                start_q, start_n;
  logic [WORD_W-1:0]   data_q, data_n;
  logic                done_q, done_n;
  logic                error_q, error_n;
  logic [IDX_W-1:0]    err_idx_q, err_idx_n;

  // {reg[6:0], val[8:0]} for each table entry
  function automatic logic [15:0] table_entry(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h062};
      4'd2:    table_entry = {7'd0,  9'h017};
      4'd3:    table_entry = {7'd1,  9'h017};
      4'd4:    table_entry = {7'd2,  9'h079};
      4'd5:    table_entry = {7'd3,  9'h079};
      4'd6:    table_entry = {7'd4,  9'h012};
      4'd7:    table_entry = {7'd5,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h00A};
      4'd9:    table_entry = {7'd8,  9'h000};
      4'd10:   table_entry = {7'd9,  9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    rty_n     = rty_q;
    pass_n    = pass_q;
    data_n    = data_q;
    done_n    = done_q;
    error_n   = error_q;
    err_idx_n = err_idx_q;

    case (state_q)
      S_DELAY: begin
        if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      // First cycle latches the word, second lets the writer capture it stable
      S_LOAD: begin
        if (cnt_q == '0) begin
          data_n = {DEV_ADDR, table_entry(idx_q)};
          cnt_n  = CNT_W'(1);
        end else begin
          state_n = S_RUN;
          cnt_n   = '0;
        end
      end
      // done is masked for two cycles in case the writer still shows the last one
      S_RUN: begin
        if ((cnt_q >= CNT_W'(2)) && i2c.i2c_done) begin
          state_n = S_CHECK;
          pass_n  = i2c.i2c_ack;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_n = S_CHECK;
          pass_n  = 1'b0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        cnt_n = '0;
        if (pass_q) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_LOAD;
            idx_n   = idx_q + IDX_W'(1);
            rty_n   = '0;
          end
        end else begin
          rty_n = rty_q + RTY_W'(1);
          if ((rty_q + RTY_W'(1)) == RTY_W'(MAX_RETRIES)) begin
            state_n   = S_ERROR;
            error_n   = 1'b1;
            err_idx_n = idx_q;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          state_n   = S_LOAD;
          cnt_n     = '0;
          idx_n     = '0;
          rty_n     = '0;
          done_n    = 1'b0;
          error_n   = 1'b0;
          err_idx_n = '0;
        end
      end
      default: state_n = S_DELAY;
    endcase

    start_n = (state_n != S_RUN);
  end

  // State and output registers; reset holds the writer idle immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_DELAY;
      cnt_q     <= '0;
      idx_q     <= '0;
      rty_q     <= '0;
      pass_q    <= 1'b0;
      start_q   <= 1'b1;
      data_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      idx_q     <= idx_n;
      rty_q     <= rty_n;
      pass_q    <= pass_n;
      start_q   <= start_n;
      data_q    <= data_n;
      done_q    <= done_n;
      error_q   <= error_n;
      err_idx_q <= err_idx_n;
    end
  end

  assign i2c.i2c_start = start_q;
  assign i2c.i2c_data  = data_q;
  assign config_done   = done_q;
  assign config_error  = error_q;
  assign err_index     = err_idx_q;

endmodule

// File: tb/tb_audio_codec_config.sv
// Bench for audio_codec_config: a behavioural I2C writer with per-attempt
// ack/nack/hang outcomes, and a table-walk model of the expected word stream.
module tb_audio_codec_config;

  localparam int unsigned INIT_DELAY  = 10;
  localparam int unsigned TIMEOUT     = 100;
  localparam int unsigned MAX_RETRIES = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       config_done;
  logic       config_error;
  logic [3:0] err_index;

  audio_codec_config_if bus ();

  audio_codec_config #(
    .INIT_DELAY (INIT_DELAY),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRIES(MAX_RETRIES),
    .DEV_ADDR   (8'h34)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart     (restart),
    .i2c         (bus),
    .config_done (config_done),
    .config_error(config_error),
    .err_index   (err_index)
  );

  always #5 clk = ~clk;

  logic [23:0] words [11] = '{24'h341E00, 24'h340C62, 24'h340017, 24'h340217,
                              24'h340479, 24'h340679, 24'h340812, 24'h340A00,
                              24'h340E0A, 24'h341000, 24'h341201};

  int n_checks = 0;
  int n_errors = 0;

  // outcome codes: 0 ack, 1 nack, 2 never finishes
  int mode;
  int plan [11][8];
  int att_cnt [11];
  logic [23:0] seen [$];
  logic [23:0] exp_q [$];
  int exp_res;
  int exp_err;

  int cyc = 0;
  int last_rise = 0;
  int low_cnt = 0;
  int cur_out = 0;
  int lat = 0;
  int stale_cnt = 0;
  int wi;
  int att;
  logic prev_start = 1'b1;
  logic prev_flag = 1'b0;
  logic flag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int outcome(input int idx, input int a);
    case (mode)
      0: return 0;
      1: return (idx == 4 && a == 0) ? 1 : 0;
      2: return (idx == 6) ? 1 : 0;
      3: return (idx == 0) ? 2 : 0;
      default: return plan[idx][a];
    endcase
  endfunction

  function automatic int word_idx(input logic [23:0] w);
    for (int i = 0; i < 11; i++) if (words[i] == w) return i;
    return 0;
  endfunction

  // Expected word stream: each entry is retried until ack or out of attempts
  task automatic build_model();
    exp_q.delete();
    exp_res = 0;
    exp_err = 0;
    for (int i = 0; i < 11; i++) begin
      int a;
      bit ok;
      a = 0;
      ok = 1'b0;
      while (a < int'(MAX_RETRIES) && !ok) begin
        exp_q.push_back(words[i]);
        if (outcome(i, a) == 0) ok = 1'b1;
        else a++;
      end
      if (!ok) begin
        exp_res = 1;
        exp_err = i;
        return;
      end
    end
  endtask

  // Writer model and output monitor, all on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_start   = 1'b1;
      prev_flag    = 1'b0;
      bus.i2c_done = 1'b0;
      bus.i2c_ack  = 1'b0;
    end else begin
      chk("exclusive", 32'(config_done & config_error), 32'd0);
      if (prev_start && !bus.i2c_start) begin
        seen.push_back(bus.i2c_data);
        wi = word_idx(bus.i2c_data);
        att = att_cnt[wi];
        att_cnt[wi]++;
        cur_out = outcome(wi, att);
        lat = $urandom_range(3, 12);
        low_cnt = 1;
        stale_cnt = 0;
        if (mode == 4 && $urandom_range(0, 1) == 1) begin
          bus.i2c_done = 1'b1;
          bus.i2c_ack  = 1'b0;
          stale_cnt = 2;
        end
      end else if (!bus.i2c_start) begin
        low_cnt++;
        if (stale_cnt > 0) begin
          stale_cnt--;
          if (stale_cnt == 0) bus.i2c_done = 1'b0;
        end
        if (lat > 0) begin
          lat--;
          if (lat == 0 && cur_out != 2) begin
            bus.i2c_done = 1'b1;
            bus.i2c_ack  = (cur_out == 0);
          end
        end
      end else begin
        if (!prev_start) begin
          last_rise = cyc;
          if (cur_out == 2) chk("timeout_len", 32'(low_cnt), 32'(TIMEOUT));
        end
        bus.i2c_done = 1'b0;
        bus.i2c_ack  = 1'b0;
      end
      flag = config_done | config_error;
      if (flag && !prev_flag) chk("flag_latency", 32'(cyc - last_rise), 32'd1);
      prev_flag  = flag;
      prev_start = bus.i2c_start;
    end
  end

  task automatic clear_obs();
    seen.delete();
    for (int i = 0; i < 11; i++) att_cnt[i] = 0;
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset_n = 1'b0;
    clear_obs();
    @(negedge clk);
    chk("rst_start", 32'(bus.i2c_start), 32'd1);
    chk("rst_data", 32'(bus.i2c_data), 32'd0);
    chk("rst_done", 32'(config_done), 32'd0);
    chk("rst_error", 32'(config_error), 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);
    reset_n = 1'b1;
    n = 0;
    while (bus.i2c_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("init_delay", 32'(n), 32'(INIT_DELAY + 2));
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(config_done || config_error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", 32'(n < 20000), 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_run();
    int m;
    chk("n_words", 32'(seen.size()), 32'(exp_q.size()));
    m = (seen.size() < exp_q.size()) ? seen.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk("word", 32'(seen[i]), 32'(exp_q[i]));
    chk("done", 32'(config_done), 32'(exp_res == 0));
    chk("error", 32'(config_error), 32'(exp_res == 1));
    chk("err_index", 32'(err_index), 32'((exp_res == 1) ? exp_err : 0));
    chk("start_idle", 32'(bus.i2c_start), 32'd1);
  endtask

  task automatic run(input int m);
    mode = m;
    build_model();
    do_reset();
    wait_end();
    compare_run();
  endtask

  task automatic wait_words(input int k);
    int n;
    n = 0;
    while (!(seen.size() >= k && !bus.i2c_start) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_words", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);

    run(0);
    run(1);
    run(2);
    run(3);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 11; i++)
        for (int a = 0; a < 8; a++)
          plan[i][a] = ($urandom_range(0, 4) == 0) ? 1 : 0;
      run(4);
    end

    // restart from DONE skips the power-up delay; restart mid-RUN is ignored
    run(0);
    clear_obs();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_clr_done", 32'(config_done), 32'd0);
    @(negedge clk);
    chk("restart_word", 32'(bus.i2c_data), 32'h341E00);
    chk("restart_start_hi", 32'(bus.i2c_start), 32'd1);
    @(negedge clk);
    chk("restart_start_lo", 32'(bus.i2c_start), 32'd0);
    wait_words(3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_end();
    compare_run();

    // asynchronous reset while index 5 is in flight
    mode = 0;
    build_model();
    do_reset();
    wait_words(6);
    chk("mid_count", 32'(seen.size()), 32'd6);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_start", 32'(bus.i2c_start), 32'd1);
    chk("async_data", 32'(bus.i2c_data), 32'd0);
    chk("async_done", 32'(config_done), 32'd0);
    chk("async_error", 32'(config_error), 32'd0);
    do_reset();
    wait_end();
    compare_run();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
